// File: rtl/hist_match_unit.sv
// L1 nearest-neighbour matcher over LBP histograms (train vs predict).
// Define HMU_THRESH_EN to gate match_valid on best_dist <= MATCH_THRESH.
module hist_match_unit #(
  parameter logic [21:0] MATCH_THRESH = 22'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  num_faces,
  input  logic [3:0]  gridX,
  input  logic [3:0]  gridY,
  output logic        hist_ren_train,
  output logic [20:0] hist_addr_train,
  input  logic [7:0]  hist_rdata_train,
  output logic        hist_ren_predict,
  output logic [13:0] hist_addr_predict,
  input  logic [7:0]  hist_rdata_predict,
  output logic [6:0]  match_id,
  output logic [21:0] match_dist,
  output logic        match_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CMP,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  nf_q, nf_d;
  logic [6:0]  ncells_q, ncells_d;
  logic [6:0]  face_q, face_d;
  logic [5:0]  cell_q, cell_d;
  logic [7:0]  bin_q, bin_d;
  logic [21:0] acc_q, acc_d;
  logic [21:0] best_dist_q, best_dist_d;
  logic [6:0]  best_id_q, best_id_d;
  logic        legal_q, legal_d;
  logic        rvalid_q, rvalid_d;
  logic [6:0]  match_id_q, match_id_d;
  logic [21:0] match_dist_q, match_dist_d;
  logic        match_valid_q, match_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  diff;
  logic [21:0] acc_sum;
  logic [6:0]  cells_in;
  logic        cfg_ok;
  logic        last_cell;
  logic        last_face;
  logic        thresh_ok;

`ifdef HMU_THRESH_EN
  assign thresh_ok = (best_dist_q <= MATCH_THRESH);
`else
  logic [21:0] unused_thresh;
  assign thresh_ok     = 1'b1;
  assign unused_thresh = MATCH_THRESH;
`endif

  always_comb begin
    if (hist_rdata_train >= hist_rdata_predict)
      diff = hist_rdata_train - hist_rdata_predict;
    else
      diff = hist_rdata_predict - hist_rdata_train;
  end

  // Read data lags its request by one cycle; rvalid_q marks it.
  assign acc_sum = acc_q
    + {14'd0, (rvalid_q ? diff : 8'd0)};

  assign cells_in = {3'd0, gridX} * {3'd0, gridY};

  assign cfg_ok = (gridX != 4'd0) && (gridX <= 4'd8)
    && (gridY != 4'd0) && (gridY <= 4'd8)
    && (num_faces != 8'd0)
    && (num_faces <= 8'd128);

  assign last_cell = ({1'b0, cell_q} == ncells_q - 7'd1);
  assign last_face = ({1'b0, face_q} == nf_q - 8'd1);

  always_comb begin
    state_d       = state_q;
    nf_d          = nf_q;
    ncells_d      = ncells_q;
    face_d        = face_q;
    cell_d        = cell_q;
    bin_d         = bin_q;
    acc_d         = acc_q;
    best_dist_d   = best_dist_q;
    best_id_d     = best_id_q;
    legal_d       = legal_q;
    rvalid_d      = (state_q == READ);
    match_id_d    = match_id_q;
    match_dist_d  = match_dist_q;
    match_valid_d = match_valid_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          nf_d          = num_faces;
          ncells_d      = cells_in;
          face_d        = 7'd0;
          cell_d        = 6'd0;
          bin_d         = 8'd0;
          acc_d         = 22'd0;
          best_dist_d   = '1;
          best_id_d     = 7'd0;
          legal_d       = cfg_ok;
          match_valid_d = 1'b0;
          busy_d        = 1'b1;
          state_d       = cfg_ok ? READ : DONE;
        end
      end
      READ: begin
        acc_d = acc_sum;
        bin_d = bin_q + 8'd1;
        if (bin_q == 8'hff) begin
          if (last_cell) begin
            cell_d  = 6'd0;
            state_d = CMP;
          end else begin
            cell_d = cell_q + 6'd1;
          end
        end
      end
      CMP: begin
        acc_d = 22'd0;
        // Strict compare so ties keep the lower id.
        if (acc_sum < best_dist_q) begin
          best_dist_d = acc_sum;
          best_id_d   = face_q;
        end
        if (last_face) begin
          state_d = DONE;
        end else begin
          face_d  = face_q + 7'd1;
          state_d = READ;
        end
      end
      DONE: begin
        done_d        = 1'b1;
        busy_d        = 1'b0;
        match_id_d    = best_id_q;
        match_dist_d  = best_dist_q;
        match_valid_d = legal_q && thresh_ok;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      nf_q          <= 8'd0;
      ncells_q      <= 7'd0;
      face_q        <= 7'd0;
      cell_q        <= 6'd0;
      bin_q         <= 8'd0;
      acc_q         <= 22'd0;
      best_dist_q   <= 22'd0;
      best_id_q     <= 7'd0;
      legal_q       <= 1'b0;
      rvalid_q      <= 1'b0;
      match_id_q    <= 7'd0;
      match_dist_q  <= 22'd0;
      match_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      nf_q          <= nf_d;
      ncells_q      <= ncells_d;
      face_q        <= face_d;
      cell_q        <= cell_d;
      bin_q         <= bin_d;
      acc_q         <= acc_d;
      best_dist_q   <= best_dist_d;
      best_id_q     <= best_id_d;
      legal_q       <= legal_d;
      rvalid_q      <= rvalid_d;
      match_id_q    <= match_id_d;
      match_dist_q  <= match_dist_d;
      match_valid_q <= match_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign hist_ren_train    = (state_q == READ);
  assign hist_ren_predict  = (state_q == READ);
  assign hist_addr_train   = {face_q, cell_q, bin_q};
  assign hist_addr_predict = {cell_q, bin_q};

  assign match_id    = match_id_q;
  assign match_dist  = match_dist_q;
  assign match_valid = match_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_hist_match_unit.sv
// Directed bench for hist_match_unit: behavioural histogram
// memories, address monitor and hand-computed results.
module tb_hist_match_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  num_faces;
  logic [3:0]  gridX;
  logic [3:0]  gridY;
  logic        hist_ren_train;
  logic [20:0] hist_addr_train;
  logic [7:0]  hist_rdata_train = 8'd0;
  logic        hist_ren_predict;
  logic [13:0] hist_addr_predict;
  logic [7:0]  hist_rdata_predict = 8'd0;
  logic [6:0]  match_id;
  logic [21:0] match_dist;
  logic        match_valid;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  int mode = 0;
  logic [7:0] pval = 8'd0;
  logic [7:0] tval [128];

  int ren_cnt = 0;
  int addr_err = 0;
  int ef = 0, ec = 0, eb = 0;
  int mon_cells = 1;
  int lat;

  always #5 clk = ~clk;

  hist_match_unit #(.MATCH_THRESH(22'd256)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .num_faces(num_faces),
    .gridX(gridX),
    .gridY(gridY),
    .hist_ren_train(hist_ren_train),
    .hist_addr_train(hist_addr_train),
    .hist_rdata_train(hist_rdata_train),
    .hist_ren_predict(hist_ren_predict),
    .hist_addr_predict(hist_addr_predict),
    .hist_rdata_predict(hist_rdata_predict),
    .match_id(match_id),
    .match_dist(match_dist),
    .match_valid(match_valid),
    .busy(busy),
    .done(done)
  );

  function automatic logic [7:0] pat(input int c, input int b);
    int v;
    v = b + 37 * c;
    return v[7:0];
  endfunction

  function automatic logic [7:0] tdata(input int f, input int c,
                                       input int b);
    if (mode == 1) return pat(c, b);
    if (mode == 2) return (b == 0) ? 8'd12 : 8'd11;
    return tval[f];
  endfunction

  function automatic logic [7:0] pdata(input int c, input int b);
    if (mode == 1) return pat(c, b);
    if (mode == 2) return 8'd10;
    return pval;
  endfunction

  always @(posedge clk) begin
    if (hist_ren_train)
      hist_rdata_train <= tdata(int'(hist_addr_train[20:14]),
                                int'(hist_addr_train[13:8]),
                                int'(hist_addr_train[7:0]));
    if (hist_ren_predict)
      hist_rdata_predict <= pdata(int'(hist_addr_predict[13:8]),
                                  int'(hist_addr_predict[7:0]));
  end

  always @(negedge clk) begin
    if (hist_ren_train || hist_ren_predict) begin
      ren_cnt++;
      if (!(hist_ren_train && hist_ren_predict)
          || hist_addr_train !== {ef[6:0], ec[5:0], eb[7:0]}
          || hist_addr_predict !== {ec[5:0], eb[7:0]})
        addr_err++;
      eb++;
      if (eb == 256) begin
        eb = 0;
        ec++;
        if (ec == mon_cells) begin
          ec = 0;
          ef++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int nf, input int gx, input int gy,
                     input bit poke, output int l);
    @(posedge clk);
    #1;
    ren_cnt = 0; addr_err = 0;
    ef = 0; ec = 0; eb = 0;
    mon_cells = gx * gy;
    @(negedge clk);
    num_faces = nf[7:0];
    gridX = gx[3:0];
    gridY = gy[3:0];
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("valid_cleared", {31'd0, match_valid}, 32'd0);
    l = 0;
    do begin
      @(posedge clk);
      #1;
      l++;
      enable = poke && l >= 100 && l < 103;
    end while (!done && l < 40000);
    enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    num_faces = 8'd0;
    gridX = 4'd0;
    gridY = 4'd0;
    for (int i = 0; i < 128; i++) tval[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_id", {25'd0, match_id}, 32'd0);
    chk("rst_dist", {10'd0, match_dist}, 32'd0);
    chk("rst_valid", {31'd0, match_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ren", {30'd0, hist_ren_train, hist_ren_predict}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1x1, two faces, enable pokes while busy
    mode = 0; pval = 8'd10;
    tval[0] = 8'd12; tval[1] = 8'd11;
    run(2, 1, 1, 1'b1, lat);
    chk("t1_lat", lat, 32'd515);
    chk("t1_id", {25'd0, match_id}, 32'd1);
    chk("t1_dist", {10'd0, match_dist}, 32'd256);
    chk("t1_valid", {31'd0, match_valid}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_ren", ren_cnt, 32'd512);
    chk("t1_addr", addr_err, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("t1_hold_dist", {10'd0, match_dist}, 32'd256);
    chk("t1_hold_done", {31'd0, done}, 32'd0);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // 2x3, four identical faces: tie keeps id 0
    mode = 1;
    run(4, 2, 3, 1'b0, lat);
    chk("t2_lat", lat, 32'd6149);
    chk("t2_id", {25'd0, match_id}, 32'd0);
    chk("t2_dist", {10'd0, match_dist}, 32'd0);
    chk("t2_ren", ren_cnt, 32'd6144);
    chk("t2_addr", addr_err, 32'd0);

    // Face 77 is the only exact match
    mode = 0; pval = 8'd0;
    for (int i = 0; i < 128; i++) tval[i] = 8'd255;
    tval[77] = 8'd0;
    run(80, 1, 1, 1'b0, lat);
    chk("t3a_lat", lat, 32'd20561);
    chk("t3a_id", {25'd0, match_id}, 32'd77);
    chk("t3a_dist", {10'd0, match_dist}, 32'd0);
    chk("t3a_addr", addr_err, 32'd0);

    // Full 8x8 grid at maximum difference
    tval[77] = 8'd255;
    run(1, 8, 8, 1'b0, lat);
    chk("t3b_lat", lat, 32'd16386);
    chk("t3b_id", {25'd0, match_id}, 32'd0);
    chk("t3b_dist", {10'd0, match_dist}, 32'd4177920);
    chk("t3b_ren", ren_cnt, 32'd16384);
    chk("t3b_addr", addr_err, 32'd0);

    // Illegal configurations
    run(1, 0, 1, 1'b0, lat);
    chk("t4a_lat", lat, 32'd1);
    chk("t4a_valid", {31'd0, match_valid}, 32'd0);
    chk("t4a_ren", ren_cnt, 32'd0);
    run(1, 1, 9, 1'b0, lat);
    chk("t4b_lat", lat, 32'd1);
    chk("t4b_valid", {31'd0, match_valid}, 32'd0);
    chk("t4b_ren", ren_cnt, 32'd0);
    run(0, 1, 1, 1'b0, lat);
    chk("t4c_lat", lat, 32'd1);
    chk("t4c_valid", {31'd0, match_valid}, 32'd0);
    chk("t4c_ren", ren_cnt, 32'd0);

    // Reset during the read of face 1
    pval = 8'd10;
    tval[0] = 8'd12; tval[1] = 8'd11;
    @(negedge clk);
    num_faces = 8'd2; gridX = 4'd1; gridY = 4'd1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("t5_pre_ren", {31'd0, hist_ren_train}, 32'd1);
    chk("t5_pre_face", {25'd0, hist_addr_train[20:14]}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_dist", {10'd0, match_dist}, 32'd0);
    chk("t5_rst_id", {25'd0, match_id}, 32'd0);
    chk("t5_rst_ren", {30'd0, hist_ren_train, hist_ren_predict},
        32'd0);
    chk("t5_rst_addr", {11'd0, hist_addr_train}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(2, 1, 1, 1'b0, lat);
    chk("t5_lat", lat, 32'd515);
    chk("t5_id", {25'd0, match_id}, 32'd1);
    chk("t5_dist", {10'd0, match_dist}, 32'd256);
    chk("t5_valid", {31'd0, match_valid}, 32'd1);

    // Distance 257 against a threshold of 256
    mode = 2;
    run(1, 1, 1, 1'b0, lat);
    chk("t6_lat", lat, 32'd258);
    chk("t6_dist", {10'd0, match_dist}, 32'd257);
`ifdef HMU_THRESH_EN
    chk("t6_valid", {31'd0, match_valid}, 32'd0);
`else
    chk("t6_valid", {31'd0, match_valid}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hist_match_unit.md
Name: hist_match_unit

Overview:
- Reads the histograms that the histogram computing unit wrote: one predict histogram and up to 128 stored training histograms.
- Computes the L1 distance (sum of absolute bin differences) between the predict histogram and each training face.
- Reports the id and distance of the closest face.
- Sits after the histogram unit in the LBP recognition flow and shares its train/predict histogram memories on their read ports.

Parameters:
- MATCH_THRESH, 22'd1000000, rejection threshold on the best distance. Used only when HMU_THRESH_EN is defined.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- enable  input  1  start request, sampled in IDLE only
- num_faces  input  8  number of training faces to scan; valid range 1..128
- gridX  input  4  grid columns; valid range 1..8
- gridY  input  4  grid rows; valid range 1..8
- hist_ren_train  output  1  train memory read enable
- hist_addr_train  output  21  train address = {face[6:0], cell[5:0], bin[7:0]}
- hist_rdata_train  input  8  train read data, valid the cycle after ren
- hist_ren_predict  output  1  predict memory read enable
- hist_addr_predict  output  14  predict address = {cell[5:0], bin[7:0]}
- hist_rdata_predict  input  8  predict read data, valid the cycle after ren
- match_id  output  7  id of best face
- match_dist  output  22  L1 distance of best face
- match_valid  output  1  result valid (config legal and, if enabled, threshold passed)
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; accumulators and counters cleared.
- Reset mid-operation aborts the scan immediately. No partial result is kept.
- States: IDLE, READ, CMP, DONE.
- IDLE:
  - On a rising clk edge with enable=1: latch num_faces, gridX, gridY; set busy=1.
  - Clear face counter, cell counter, bin counter, accumulator; set best_dist=all ones, best_id=0.
  - If gridX or gridY is 0 or >8, or num_faces is 0 or >128: go to DONE with match_valid=0.
  - Otherwise go to READ.
- Geometry: N = gridX*gridY*256 bins per face. Cell index is linear, 0..gridX*gridY-1. Bin increments fastest.
- READ:
  - Every cycle assert both ren signals with addresses for the current (face, cell, bin).
  - Exactly N consecutive read cycles per face.
  - Data returned one cycle later is accumulated as acc += |train - predict| (8-bit unsigned difference, zero-extended to 22 bits).
  - No overflow is possible: max 64*256*255 = 4177920 < 2^22.
  - After the Nth read go to CMP.
- CMP (ren low, one cycle):
  - Accumulate the last returned data.
  - Compare the final face distance against best_dist. Strictly less updates best_dist and best_id, so ties keep the lower id.
  - Clear acc.
  - If more faces remain, increment face and return to READ. Otherwise go to DONE.
- Timing: each face takes exactly N+1 cycles.
- DONE (one cycle):
  - done=1, busy=0 on exit.
  - match_id and match_dist take their new values; match_valid=1 for a legal configuration.
  - Then return to IDLE.
- Outputs hold their values until the next accepted start. On an accepted start, match_valid clears.
- enable while busy is ignored. enable held high after done starts a new scan from IDLE.
- Done timing: for a legal configuration, done is high in the cycle that begins F*(N+1)+1 clock edges after the accepting edge, where F = num_faces. For an illegal configuration, done is high in the cycle immediately after the accepting edge.
- Read enables are never asserted outside READ.

Optional Feature:
- Macro: HMU_THRESH_EN.
- Defined: in DONE, match_valid=1 only if the configuration is legal and best_dist <= MATCH_THRESH. match_id and match_dist are still reported.
- Undefined: no threshold check; MATCH_THRESH has no effect.

Test Plan:
- gridX=1, gridY=1, F=2; predict bins all 10, face0 all 12, face1 all 11 -> match_id=1, match_dist=256, match_valid=1; done is high after 1+2*257 edges.
- gridX=2, gridY=3, F=4; all train faces equal to predict -> match_id=0, match_dist=0. Check the address sequence: bin, then cell, then face, with no gaps inside READ.
- gridX=8, gridY=8, F=128; predict all 0, all train 255 except face 77 all 0 -> match_id=77, match_dist=0. Separately, all train 255 -> match_id=0, match_dist=4177920 (no overflow).
- Illegal configs (gridX=0; gridY=9; num_faces=0) -> done one cycle after start, match_valid=0, ren never asserted.
- rst pulsed during READ of face 1 -> all outputs 0 immediately. A following enable runs the full scan and gives the correct result.
- HMU_THRESH_EN with MATCH_THRESH=100, best distance 256 -> match_valid=0, match_dist=256. With MATCH_THRESH=256 -> match_valid=1. Also check that enable pulses during busy are ignored.
